// File: rtl/snake_pkg.sv
// Shared types and codes for the snake engine: move/restart codes, game states,
// pixel classes and the reverse-direction helper.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2,
        ST_WIN  = 2'd3
    } state_t;

    localparam logic [1:0] MV_RIGHT = 2'd0;
    localparam logic [1:0] MV_DOWN  = 2'd1;
    localparam logic [1:0] MV_LEFT  = 2'd2;
    localparam logic [1:0] MV_UP    = 2'd3;
    localparam logic [2:0] DIR_RESTART = 3'b100;

    localparam logic [2:0] PIX_BG    = 3'd0;
    localparam logic [2:0] PIX_WALL  = 3'd1;
    localparam logic [2:0] PIX_APPLE = 3'd2;
    localparam logic [2:0] PIX_HEAD  = 3'd3;
    localparam logic [2:0] PIX_BODY  = 3'd4;
    localparam logic [2:0] PIX_BLANK = 3'd7;

    // Move codes are laid out so that flipping bit 1 gives the reverse direction.
    function automatic logic [1:0] opposite(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Movement tick generator: counts enabled cycles and pulses tick for one cycle
// every TICK_DIV cycles; clr restarts the count from zero.
module snake_tick_gen #(
    parameter int TICK_DIV = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TC = TW'(TICK_DIV - 1);

    logic [TW-1:0] cnt;

    assign tick = en && (cnt == TC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/snake_core.sv
// Snake game engine: body/apple/score state, step FSM and a registered pixel classifier.
// Define SNAKE_WRAP_EN for a wall-less playfield where the head wraps at the grid edges.
module snake_core
    import snake_pkg::*;
#(
    parameter int GRID_W     = 40,
    parameter int GRID_H     = 30,
    parameter int CELL_PX    = 20,
    parameter int MAX_LEN    = 32,
    parameter int TICK_DIV   = 5000000,
    parameter int WIN_POINTS = 30,
    localparam int CW = $clog2((GRID_W > GRID_H) ? GRID_W : GRID_H),
    localparam int PW = $clog2(WIN_POINTS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          display_en,
    input  logic [10:0]   x_pos,
    input  logic [10:0]   y_pos,
    input  logic [2:0]    direction,
    input  logic [CW-1:0] rand_x,
    input  logic [CW-1:0] rand_y,
    output logic [2:0]    pix_class,
    output logic [1:0]    game_state,
    output logic [PW-1:0] points
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] XMAX   = CW'(GRID_W - 1);
    localparam logic [CW-1:0] YMAX   = CW'(GRID_H - 1);
    localparam logic [CW-1:0] HOME_X = CW'(GRID_W / 2);
    localparam logic [CW-1:0] HOME_Y = CW'(GRID_H / 2);
    localparam logic [CW-1:0] APPLE0 = CW'(2);
    localparam logic [CW-1:0] PARK   = '1;

    state_t        state, state_nx;
    logic [1:0]    cur_dir;
    logic [CW-1:0] seg_x [MAX_LEN];
    logic [CW-1:0] seg_y [MAX_LEN];
    logic [CW-1:0] head_x, head_y, nh_x, nh_y, apple_x, apple_y;
    logic [LW-1:0] len;
    logic          apple_pend, tick, is_move, restart, dir_ok;
    logic          wall_hit, body_hit, eat, apple_ok, advance;
    logic [10:0]   cell_x, cell_y;
    logic          px_head, px_body, px_apple, px_wall;
    logic [2:0]    pix_nx;

    assign head_x     = seg_x[0];
    assign head_y     = seg_y[0];
    assign game_state = state;
    assign is_move    = ~direction[2];
    assign restart    = (direction == DIR_RESTART);
    assign dir_ok     = is_move && !(len > LW'(1) && direction[1:0] == opposite(cur_dir));

    snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_PLAY),
        .clr  (restart || (state == ST_IDLE && is_move)),
        .tick (tick)
    );

    always_comb begin
        nh_x = head_x;
        nh_y = head_y;
        case (cur_dir)
`ifdef SNAKE_WRAP_EN
            MV_RIGHT: nh_x = (head_x == XMAX) ? '0 : head_x + 1'b1;
            MV_LEFT:  nh_x = (head_x == '0) ? XMAX : head_x - 1'b1;
            MV_DOWN:  nh_y = (head_y == YMAX) ? '0 : head_y + 1'b1;
            MV_UP:    nh_y = (head_y == '0) ? YMAX : head_y - 1'b1;
`else
            MV_RIGHT: nh_x = head_x + 1'b1;
            MV_LEFT:  nh_x = head_x - 1'b1;
            MV_DOWN:  nh_y = head_y + 1'b1;
            MV_UP:    nh_y = head_y - 1'b1;
`endif
        endcase
`ifdef SNAKE_WRAP_EN
        wall_hit = 1'b0;
        apple_ok = rand_x <= XMAX && rand_y <= YMAX;
`else
        wall_hit = nh_x == '0 || nh_x == XMAX || nh_y == '0 || nh_y == YMAX;
        apple_ok = rand_x != '0 && rand_x < XMAX && rand_y != '0 && rand_y < YMAX;
`endif
        apple_ok = apple_ok && !(rand_x == head_x && rand_y == head_y);
        eat = !apple_pend && nh_x == apple_x && nh_y == apple_y;
        // The tail vacates on a plain move, so it only kills when the snake grows.
        body_hit = 1'b0;
        for (int k = 1; k < MAX_LEN; k++)
            if ((k + 1 < int'(len) || (eat && k + 1 == int'(len))) &&
                seg_x[k] == nh_x && seg_y[k] == nh_y)
                body_hit = 1'b1;
        advance = state == ST_PLAY && tick && !restart && !wall_hit && !body_hit;

        state_nx = state;
        if (restart)
            state_nx = ST_IDLE;
        else begin
            case (state)
                ST_IDLE: if (is_move) state_nx = ST_PLAY;
                ST_PLAY: begin
                    if (tick) begin
                        if (wall_hit || body_hit)
                            state_nx = ST_DEAD;
                        else if (eat && points == PW'(WIN_POINTS - 1))
                            state_nx = ST_WIN;
                    end
                end
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_dir    <= MV_RIGHT;
            len        <= LW'(1);
            points     <= '0;
            apple_x    <= APPLE0;
            apple_y    <= APPLE0;
            apple_pend <= 1'b0;
            for (int k = 0; k < MAX_LEN; k++) begin
                seg_x[k] <= (k == 0) ? HOME_X : PARK;
                seg_y[k] <= (k == 0) ? HOME_Y : PARK;
            end
        end else if (restart) begin
            cur_dir    <= MV_RIGHT;
            len        <= LW'(1);
            points     <= '0;
            apple_x    <= APPLE0;
            apple_y    <= APPLE0;
            apple_pend <= 1'b0;
            for (int k = 0; k < MAX_LEN; k++) begin
                seg_x[k] <= (k == 0) ? HOME_X : PARK;
                seg_y[k] <= (k == 0) ? HOME_Y : PARK;
            end
        end else begin
            if (dir_ok)
                cur_dir <= direction[1:0];
            if (advance) begin
                seg_x[0] <= nh_x;
                seg_y[0] <= nh_y;
                // Copying one slot past the tail gives a freshly grown tail its position.
                for (int k = 1; k < MAX_LEN; k++)
                    if (k <= int'(len)) begin
                        seg_x[k] <= seg_x[k-1];
                        seg_y[k] <= seg_y[k-1];
                    end
                if (eat) begin
                    if (len != LW'(MAX_LEN))
                        len <= len + 1'b1;
                    points     <= points + 1'b1;
                    apple_pend <= 1'b1;
                end
            end
            if (apple_pend && apple_ok) begin
                apple_x    <= rand_x;
                apple_y    <= rand_y;
                apple_pend <= 1'b0;
            end
        end
    end

    assign cell_x = x_pos / 11'(CELL_PX);
    assign cell_y = y_pos / 11'(CELL_PX);

    always_comb begin
        px_head = cell_x == 11'(head_x) && cell_y == 11'(head_y);
        px_body = 1'b0;
        for (int k = 1; k < MAX_LEN; k++)
            if (k < int'(len) && cell_x == 11'(seg_x[k]) && cell_y == 11'(seg_y[k]))
                px_body = 1'b1;
        px_apple = !apple_pend && cell_x == 11'(apple_x) && cell_y == 11'(apple_y);
`ifdef SNAKE_WRAP_EN
        px_wall = 1'b0;
`else
        px_wall = cell_x < 11'(GRID_W) && cell_y < 11'(GRID_H) &&
                  (cell_x == '0 || cell_x == 11'(GRID_W - 1) ||
                   cell_y == '0 || cell_y == 11'(GRID_H - 1));
`endif
        if (!display_en)   pix_nx = PIX_BLANK;
        else if (px_head)  pix_nx = PIX_HEAD;
        else if (px_body)  pix_nx = PIX_BODY;
        else if (px_apple) pix_nx = PIX_APPLE;
        else if (px_wall)  pix_nx = PIX_WALL;
        else               pix_nx = PIX_BG;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pix_class <= PIX_BLANK;
        else
            pix_class <= pix_nx;
    end

endmodule

// File: tb/tb_snake_core.sv
// Directed bench for snake_core (default walled build, TICK_DIV=4): pixel vector
// table at reset, then scripted games covering movement, eating, collisions and restart.
module tb_snake_core;
    localparam int CW = 6;
    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          display_en;
    logic [10:0]   x_pos, y_pos;
    logic [2:0]    direction;
    logic [CW-1:0] rand_x, rand_y;
    logic [2:0]    pix_class;
    logic [1:0]    game_state;
    logic [PW-1:0] points;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int   x;
        int   y;
        logic en;
        int   cls;
    } pix_vec_t;

    pix_vec_t vecs[11];

    always #5 clk = ~clk;

    snake_core #(
        .GRID_W(40), .GRID_H(30), .CELL_PX(20), .MAX_LEN(32),
        .TICK_DIV(4), .WIN_POINTS(30)
    ) dut (
        .clk(clk), .rst(rst), .display_en(display_en),
        .x_pos(x_pos), .y_pos(y_pos), .direction(direction),
        .rand_x(rand_x), .rand_y(rand_y),
        .pix_class(pix_class), .game_state(game_state), .points(points)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_head(input string name, input int ex, input int ey);
        check({name, "_x"}, int'(dut.head_x), ex);
        check({name, "_y"}, int'(dut.head_y), ey);
    endtask

    // Advance through n movement steps; each wait for a tick is bounded.
    task automatic wait_ticks(input int n);
        int bound;
        for (int i = 0; i < n; i++) begin
            bound = 0;
            while (dut.tick !== 1'b1 && bound < 16) begin
                @(negedge clk);
                bound++;
            end
            check("tick_seen", int'(dut.tick === 1'b1), 1);
            @(negedge clk);
        end
    endtask

    task automatic move(input logic [1:0] d, input int n);
        direction = {1'b0, d};
        @(negedge clk);
        direction = 3'b111;
        wait_ticks(n);
    endtask

    task automatic pix_probe(input string name, input int x, input int y, input int cls);
        x_pos = 11'(x);
        y_pos = 11'(y);
        display_en = 1'b1;
        @(negedge clk);
        check(name, int'(pix_class), cls);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bound;
        vecs[0]  = '{400, 300, 1'b1, 3};
        vecs[1]  = '{419, 319, 1'b1, 3};
        vecs[2]  = '{420, 300, 1'b1, 0};
        vecs[3]  = '{399, 300, 1'b1, 0};
        vecs[4]  = '{40,  40,  1'b1, 2};
        vecs[5]  = '{59,  59,  1'b1, 2};
        vecs[6]  = '{0,   0,   1'b1, 1};
        vecs[7]  = '{780, 100, 1'b1, 1};
        vecs[8]  = '{100, 580, 1'b1, 1};
        vecs[9]  = '{100, 20,  1'b1, 0};
        vecs[10] = '{400, 300, 1'b0, 7};

        rst = 1'b1; display_en = 1'b0; x_pos = '0; y_pos = '0;
        direction = 3'b111; rand_x = '0; rand_y = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_pix", int'(pix_class), 7);
        check("rst_state", int'(game_state), 0);
        check("rst_points", int'(points), 0);
        check("rst_len", int'(dut.len), 1);
        check_head("rst_head", 20, 15);

        for (int i = 0; i < 11; i++) begin
            x_pos = 11'(vecs[i].x);
            y_pos = 11'(vecs[i].y);
            display_en = vecs[i].en;
            @(negedge clk);
            check($sformatf("pix_vec%0d", i), int'(pix_class), vecs[i].cls);
        end

        // First move code starts the game; steps land 4 cycles apart.
        direction = 3'b000;
        @(negedge clk);
        direction = 3'b111;
        check("play_entry", int'(game_state), 1);
        repeat (3) @(negedge clk);
        check_head("pre_tick", 20, 15);
        @(negedge clk);
        check_head("tick1", 21, 15);
        repeat (4) @(negedge clk);
        check_head("tick2", 22, 15);

        pix_probe("pix_head_22_15", 440, 300, 3);
        display_en = 1'b0;
        @(negedge clk);
        check("pix_blank", int'(pix_class), 7);

        // Steer onto the reset apple at (2,2).
        move(2'd3, 13);
        check_head("up13", 22, 2);
        move(2'd2, 19);
        check("pre_eat_points", int'(points), 0);
        wait_ticks(1);
        check("eat1_points", int'(points), 1);
        check("eat1_len", int'(dut.len), 2);
        check("eat1_pend", int'(dut.apple_pend), 1);
        check_head("eat1", 2, 2);

        rand_x = 6'd0; rand_y = 6'd5;
        @(negedge clk);
        check("apple_reject_wall", int'(dut.apple_pend), 1);
        rand_x = 6'd7; rand_y = 6'd9;
        @(negedge clk);
        check("apple_accept", int'(dut.apple_pend), 0);
        check("apple_x", int'(dut.apple_x), 7);
        check("apple_y", int'(dut.apple_y), 9);
        rand_x = '0; rand_y = '0;

        // Reversal rejected while len>1.
        direction = 3'b000;
        @(negedge clk);
        direction = 3'b111;
        check("reverse_rejected", int'(dut.cur_dir), 2);
        wait_ticks(1);
        check_head("still_left", 1, 2);
        move(2'd1, 1);
        check_head("turn_down", 1, 3);
        wait_ticks(6);
        move(2'd0, 6);
        check("eat2_points", int'(points), 2);
        check("eat2_len", int'(dut.len), 3);
        check_head("eat2", 7, 9);

        rand_x = 6'd8; rand_y = 6'd9;
        @(negedge clk);
        rand_x = '0; rand_y = '0;
        wait_ticks(1);
        check("eat3_len", int'(dut.len), 4);

        // len=4 loop closing onto its own tail survives.
        move(2'd1, 1);
        move(2'd2, 1);
        move(2'd3, 1);
        check("tail_close_alive", int'(game_state), 1);
        check_head("tail_close", 7, 9);

        rand_x = 6'd7; rand_y = 6'd8;
        @(negedge clk);
        rand_x = '0; rand_y = '0;
        wait_ticks(1);
        check("eat4_points", int'(points), 4);
        check("eat4_len", int'(dut.len), 5);

        // len=5 U-turn runs into segment 3.
        move(2'd0, 1);
        move(2'd1, 1);
        check("uturn_alive", int'(game_state), 1);
        move(2'd2, 1);
        check("self_hit_dead", int'(game_state), 2);
        check_head("self_hit", 8, 9);
        pix_probe("pix_body", 140, 200, 4);
        pix_probe("pix_head_dead", 160, 180, 3);

        direction = 3'b001;
        @(negedge clk);
        direction = 3'b111;
        repeat (8) @(negedge clk);
        check("dead_frozen_state", int'(game_state), 2);
        check_head("dead_frozen", 8, 9);

        direction = 3'b100;
        @(negedge clk);
        direction = 3'b111;
        check("restart_state", int'(game_state), 0);
        check("restart_points", int'(points), 0);
        check("restart_len", int'(dut.len), 1);
        check_head("restart", 20, 15);

        // Right wall: col 38 is the last legal column.
        move(2'd0, 18);
        check_head("at_col38", 38, 15);
        check("col38_alive", int'(game_state), 1);
        wait_ticks(1);
        check("wall_dead", int'(game_state), 2);
        check_head("wall", 38, 15);

        // Restart lands in the same cycle as a tick.
        direction = 3'b100;
        @(negedge clk);
        direction = 3'b000;
        @(negedge clk);
        direction = 3'b111;
        bound = 0;
        while (dut.tick !== 1'b1 && bound < 16) begin
            @(negedge clk);
            bound++;
        end
        check("tick_before_restart", int'(dut.tick === 1'b1), 1);
        direction = 3'b100;
        @(negedge clk);
        direction = 3'b111;
        check("tick_restart_state", int'(game_state), 0);
        check("tick_restart_len", int'(dut.len), 1);
        check("tick_restart_points", int'(points), 0);
        check_head("tick_restart", 20, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
